trdb_word_arbiter: RTL and testbench

- Shares one trace output word port between NUM_SRC trace debugger instances, e.g. one per core in a cluster.
- Each source presents a packet word stream: word, valid, last, with a grant handshake, as produced by the stream aligner.
- Arbitration is round-robin at packet granularity. A packet's words are never interleaved with another source's words.
- Output goes through a single registered valid/ready stage toward the trace sink.

---
 rtl/trdb_pkg.sv | 18 +
 rtl/trdb_rr_select.sv | 30 +++
 rtl/trdb_word_arbiter.sv | 173 +++++++++++++++++
 tb/tb_trdb_word_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/trdb_pkg.sv
// Shared types and constants for the trace debugger multi-source blocks.
// Header fields apply only when TRDB_ARB_HEADER_EN is defined.
package trdb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HEADER = 2'd1,
      LOCKED = 2'd2
   } arb_state_e;

   localparam logic [7:0] TRDB_ARB_HDR_MAGIC = 8'hA5;

   // Header word layout: magic in the top byte, source id and sequence number at the bottom
   localparam int unsigned TRDB_ARB_HDR_FIELD_W  = 8;
   localparam int unsigned TRDB_ARB_HDR_SRC_LSB  = 8;
   localparam int unsigned TRDB_ARB_HDR_SEQ_LSB  = 0;

endpackage

// File: rtl/trdb_rr_select.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module trdb_rr_select #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     winner_c,
   output logic [IDX_W-1:0] winner_idx_c,
   output logic             found_c
);

   always_comb begin : pick
      int unsigned cand;
      cand         = 0;
      winner_c     = '0;
      winner_idx_c = '0;
      found_c      = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = 32'(ptr) + k;
         if (cand >= N) cand = cand - N;
         if (!found_c && req[IDX_W'(cand)]) begin
            found_c            = 1'b1;
            winner_c[IDX_W'(cand)] = 1'b1;
            winner_idx_c       = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/trdb_word_arbiter.sv
// Packet-granular round-robin arbiter sharing one registered trace word port.
// Optional TRDB_ARB_HEADER_EN prefixes every packet with a source/sequence header word.
module trdb_word_arbiter
   import trdb_pkg::*;
#(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned XLEN    = 32,
   parameter int unsigned CNT_W   = 16,
   localparam int unsigned SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NUM_SRC*XLEN-1:0] src_word_i,
   input  logic [NUM_SRC-1:0]      src_valid_i,
   input  logic [NUM_SRC-1:0]      src_last_i,
   output logic [NUM_SRC-1:0]      src_grant_o,
   output logic [XLEN-1:0]         word_o,
   output logic                    word_valid_o,
   output logic                    word_last_o,
   output logic [SRC_W-1:0]        word_src_o,
   input  logic                    word_ready_i,
   output logic [CNT_W-1:0]        pkt_cnt_o
);

   arb_state_e         state_q, state_d;
   logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [SRC_W-1:0]   owner_q, owner_d;

   logic [XLEN-1:0]    words [NUM_SRC];
   logic [NUM_SRC-1:0] rr_onehot;
   logic [SRC_W-1:0]   rr_idx;
   logic               rr_found;

   logic               out_free;
   logic [SRC_W-1:0]   sel_idx;
   logic [NUM_SRC-1:0] sel_onehot;
   logic [XLEN-1:0]    sel_word;
   logic               sel_last;

   logic               grant_en;
   logic               load_valid;
   logic [XLEN-1:0]    load_word;
   logic               load_last;
   logic [SRC_W-1:0]   load_src;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_words
      assign words[g] = src_word_i[g*XLEN +: XLEN];
   end

   trdb_rr_select #(
      .N     (NUM_SRC),
      .IDX_W (SRC_W)
   ) u_rr_select (
      .req          (src_valid_i),
      .ptr          (rr_ptr_q),
      .winner_c     (rr_onehot),
      .winner_idx_c (rr_idx),
      .found_c      (rr_found)
   );

   function automatic logic [SRC_W-1:0] next_ptr(input logic [SRC_W-1:0] idx);
      if (32'(idx) >= NUM_SRC - 1) return '0;
      return SRC_W'(idx + SRC_W'(1));
   endfunction

   assign out_free   = !word_valid_o || word_ready_i;
   assign sel_idx    = (state_q == LOCKED) ? owner_q : rr_idx;
   assign sel_onehot = (state_q == LOCKED) ? (NUM_SRC'(1) << owner_q) : rr_onehot;
   assign sel_word   = words[sel_idx];
   assign sel_last   = src_last_i[sel_idx];

   assign src_grant_o = grant_en ? sel_onehot : '0;

`ifdef TRDB_ARB_HEADER_EN
   logic [7:0]      seq_q [NUM_SRC];
   logic [XLEN-1:0] hdr_word;
   logic            hdr_load;

   always_comb begin
      hdr_word = '0;
      hdr_word[XLEN-1 -: TRDB_ARB_HDR_FIELD_W] = TRDB_ARB_HDR_MAGIC;
      hdr_word[TRDB_ARB_HDR_SRC_LSB +: TRDB_ARB_HDR_FIELD_W] = 8'(rr_idx);
      hdr_word[TRDB_ARB_HDR_SEQ_LSB +: TRDB_ARB_HDR_FIELD_W] = seq_q[rr_idx];
   end

   // Per-source sequence numbers advance each time that source's header is emitted
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned s = 0; s < NUM_SRC; s++) seq_q[s] <= '0;
      end else if (hdr_load) begin
         seq_q[rr_idx] <= seq_q[rr_idx] + 8'd1;
      end
   end
`endif

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      grant_en   = 1'b0;
      load_valid = 1'b0;
      load_word  = sel_word;
      load_last  = sel_last;
      load_src   = sel_idx;
`ifdef TRDB_ARB_HEADER_EN
      hdr_load   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (rr_found && out_free) begin
               load_valid = 1'b1;
`ifdef TRDB_ARB_HEADER_EN
               // Packet start is replaced by its header; the source waits one word
               hdr_load  = 1'b1;
               load_word = hdr_word;
               load_last = 1'b0;
               state_d   = LOCKED;
               owner_d   = rr_idx;
`else
               grant_en = 1'b1;
               if (sel_last) begin
                  rr_ptr_d = next_ptr(rr_idx);
               end else begin
                  state_d = LOCKED;
                  owner_d = rr_idx;
               end
`endif
            end
         end
         LOCKED: begin
            // Lock is held indefinitely while the owner is silent
            if (src_valid_i[owner_q] && out_free) begin
               grant_en   = 1'b1;
               load_valid = 1'b1;
               if (sel_last) begin
                  state_d  = IDLE;
                  rr_ptr_d = next_ptr(owner_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         owner_q      <= '0;
         word_o       <= '0;
         word_valid_o <= 1'b0;
         word_last_o  <= 1'b0;
         word_src_o   <= '0;
         pkt_cnt_o    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         if (out_free) begin
            word_valid_o <= load_valid;
            if (load_valid) begin
               word_o      <= load_word;
               word_last_o <= load_last;
               word_src_o  <= load_src;
            end
         end
         if (word_valid_o && word_ready_i && word_last_o) begin
            pkt_cnt_o <= pkt_cnt_o + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_trdb_word_arbiter.sv
// Directed bench for trdb_word_arbiter (4 sources, 32-bit words); header build when TRDB_ARB_HEADER_EN is defined.
module tb_trdb_word_arbiter;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [127:0] src_word_i;
   logic [3:0]   src_valid_i;
   logic [3:0]   src_last_i;
   logic [3:0]   src_grant_o;
   logic [31:0]  word_o;
   logic         word_valid_o;
   logic         word_last_o;
   logic [1:0]   word_src_o;
   logic         word_ready_i;
   logic [15:0]  pkt_cnt_o;

   int errors = 0;
   int checks = 0;

   trdb_word_arbiter #(.NUM_SRC(4), .XLEN(32), .CNT_W(16)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .src_word_i   (src_word_i),
      .src_valid_i  (src_valid_i),
      .src_last_i   (src_last_i),
      .src_grant_o  (src_grant_o),
      .word_o       (word_o),
      .word_valid_o (word_valid_o),
      .word_last_o  (word_last_o),
      .word_src_o   (word_src_o),
      .word_ready_i (word_ready_i),
      .pkt_cnt_o    (pkt_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [3:0]  valid;
      logic [3:0]  last;
      logic        ready;
      logic [31:0] base;
      logic [3:0]  exp_grant;
      logic        exp_valid;
      logic [31:0] exp_word;
      logic        exp_last;
      logic [1:0]  exp_src;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs [14];

   function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] last, input logic ready,
                               input logic [31:0] base, input logic [3:0] grant, input logic ov,
                               input logic [31:0] ow, input logic ol, input logic [1:0] os,
                               input logic [15:0] cnt);
      vec_t v;
      v.valid = valid; v.last = last; v.ready = ready; v.base = base;
      v.exp_grant = grant; v.exp_valid = ov; v.exp_word = ow; v.exp_last = ol;
      v.exp_src = os; v.exp_cnt = cnt;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Source s presents base + s
   task automatic drv(input logic [3:0] valid, input logic [3:0] last, input logic ready,
                      input logic [31:0] base);
      src_valid_i  = valid;
      src_last_i   = last;
      word_ready_i = ready;
      src_word_i   = {base + 32'd3, base + 32'd2, base + 32'd1, base};
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // One cycle: drive, check combinational grant, clock, check registered outputs
   task automatic cyc(input string nm, input logic [3:0] valid, input logic [3:0] last,
                      input logic ready, input logic [31:0] base, input logic [3:0] grant,
                      input logic ov, input logic [31:0] ow, input logic ol,
                      input logic [1:0] os, input logic [15:0] cnt);
      drv(valid, last, ready, base);
      #1;
      chk({nm, " grant"}, 64'(src_grant_o), 64'(grant));
      step();
      chk({nm, " valid"}, 64'(word_valid_o), 64'(ov));
      chk({nm, " cnt"}, 64'(pkt_cnt_o), 64'(cnt));
      if (ov) begin
         chk({nm, " word"}, 64'(word_o), 64'(ow));
         chk({nm, " last"}, 64'(word_last_o), 64'(ol));
         chk({nm, " src"}, 64'(word_src_o), 64'(os));
      end
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      drv(4'h0, 4'h0, 1'b1, 32'h0);
      step();
      step();
      chk("rst valid", 64'(word_valid_o), 64'd0);
      chk("rst word", 64'(word_o), 64'd0);
      chk("rst last", 64'(word_last_o), 64'd0);
      chk("rst src", 64'(word_src_o), 64'd0);
      chk("rst cnt", 64'(pkt_cnt_o), 64'd0);
      rst_i = 1'b0;
   endtask

   initial begin
      do_reset();
`ifndef TRDB_ARB_HEADER_EN
      // Single-word round robin, then a 5-cycle output stall with changing source words
      vecs[0]  = mk(4'hF, 4'hF, 1'b1, 32'h1000_0000, 4'h1, 1'b1, 32'h1000_0000, 1'b1, 2'd0, 16'd0);
      vecs[1]  = mk(4'hF, 4'hF, 1'b1, 32'h1000_0000, 4'h2, 1'b1, 32'h1000_0001, 1'b1, 2'd1, 16'd1);
      vecs[2]  = mk(4'hF, 4'hF, 1'b1, 32'h1000_0000, 4'h4, 1'b1, 32'h1000_0002, 1'b1, 2'd2, 16'd2);
      vecs[3]  = mk(4'hF, 4'hF, 1'b1, 32'h1000_0000, 4'h8, 1'b1, 32'h1000_0003, 1'b1, 2'd3, 16'd3);
      vecs[4]  = mk(4'hF, 4'hF, 1'b1, 32'h1000_0000, 4'h1, 1'b1, 32'h1000_0000, 1'b1, 2'd0, 16'd4);
      vecs[5]  = mk(4'h0, 4'hF, 1'b1, 32'h1000_0000, 4'h0, 1'b0, 32'h0, 1'b0, 2'd0, 16'd5);
      vecs[6]  = mk(4'h5, 4'hF, 1'b0, 32'h1000_0000, 4'h4, 1'b1, 32'h1000_0002, 1'b1, 2'd2, 16'd5);
      for (int i = 7; i < 12; i++)
         vecs[i] = mk(4'h5, 4'hF, 1'b0, 32'h2000_0000, 4'h0, 1'b1, 32'h1000_0002, 1'b1, 2'd2, 16'd5);
      vecs[12] = mk(4'h5, 4'hF, 1'b1, 32'h3000_0000, 4'h1, 1'b1, 32'h3000_0000, 1'b1, 2'd0, 16'd6);
      vecs[13] = mk(4'h0, 4'hF, 1'b1, 32'h3000_0000, 4'h0, 1'b0, 32'h0, 1'b0, 2'd0, 16'd7);

      for (int i = 0; i < 14; i++)
         cyc($sformatf("vec%0d", i), vecs[i].valid, vecs[i].last, vecs[i].ready, vecs[i].base,
             vecs[i].exp_grant, vecs[i].exp_valid, vecs[i].exp_word, vecs[i].exp_last,
             vecs[i].exp_src, vecs[i].exp_cnt);

      // Three-word packet from source 1 while source 2 waits
      cyc("pkt A", 4'h6, 4'h4, 1'b1, 32'h4000_00A0, 4'h2, 1'b1, 32'h4000_00A1, 1'b0, 2'd1, 16'd7);
      cyc("pkt B", 4'h6, 4'h4, 1'b1, 32'h4000_00B0, 4'h2, 1'b1, 32'h4000_00B1, 1'b0, 2'd1, 16'd7);
      cyc("pkt C", 4'h6, 4'h6, 1'b1, 32'h4000_00C0, 4'h2, 1'b1, 32'h4000_00C1, 1'b1, 2'd1, 16'd7);
      cyc("pkt src2", 4'h4, 4'h4, 1'b1, 32'h4000_00D0, 4'h4, 1'b1, 32'h4000_00D2, 1'b1, 2'd2, 16'd8);
      cyc("pkt idle", 4'h0, 4'h0, 1'b1, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 2'd0, 16'd9);

      // Owner 0 goes silent mid-packet while source 3 requests
      cyc("own start", 4'h1, 4'h0, 1'b1, 32'h5000_0000, 4'h1, 1'b1, 32'h5000_0000, 1'b0, 2'd0, 16'd9);
      for (int i = 0; i < 4; i++)
         cyc($sformatf("own gap%0d", i), 4'h8, 4'h8, 1'b1, 32'h5000_0000, 4'h0, 1'b0, 32'h0, 1'b0, 2'd0, 16'd9);
      cyc("own end", 4'h9, 4'h9, 1'b1, 32'h5100_0000, 4'h1, 1'b1, 32'h5100_0000, 1'b1, 2'd0, 16'd9);
      cyc("own src3", 4'h8, 4'h8, 1'b1, 32'h5100_0000, 4'h8, 1'b1, 32'h5100_0003, 1'b1, 2'd3, 16'd10);
      cyc("own idle", 4'h0, 4'h0, 1'b1, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 2'd0, 16'd11);

      // Reset while locked on source 1 drops the packet and returns priority to source 0
      cyc("rl start", 4'h2, 4'h0, 1'b1, 32'h6000_0000, 4'h2, 1'b1, 32'h6000_0001, 1'b0, 2'd1, 16'd11);
      rst_i = 1'b1;
      step();
      chk("rl valid", 64'(word_valid_o), 64'd0);
      chk("rl cnt", 64'(pkt_cnt_o), 64'd0);
      chk("rl word", 64'(word_o), 64'd0);
      rst_i = 1'b0;
      cyc("rl after", 4'h3, 4'h3, 1'b1, 32'h6100_0000, 4'h1, 1'b1, 32'h6100_0000, 1'b1, 2'd0, 16'd0);
      cyc("rl idle", 4'h0, 4'h0, 1'b1, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 2'd0, 16'd1);
`else
      // Two single-word packets from source 2, each preceded by its header
      cyc("hdr0", 4'h4, 4'h4, 1'b1, 32'h7000_0000, 4'h0, 1'b1, 32'hA500_0200, 1'b0, 2'd2, 16'd0);
      cyc("w0", 4'h4, 4'h4, 1'b1, 32'h7000_0000, 4'h4, 1'b1, 32'h7000_0002, 1'b1, 2'd2, 16'd0);
      cyc("hdr1", 4'h4, 4'h4, 1'b1, 32'h7100_0000, 4'h0, 1'b1, 32'hA500_0201, 1'b0, 2'd2, 16'd1);
      cyc("w1", 4'h4, 4'h4, 1'b1, 32'h7100_0000, 4'h4, 1'b1, 32'h7100_0002, 1'b1, 2'd2, 16'd1);
      cyc("hdr idle", 4'h0, 4'h0, 1'b1, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 2'd0, 16'd2);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
